// File: rtl/fifo_pack_writer.sv
// fifo_pack_writer
//   Valid/ready to FIFO write adapter. Packs PACK_RATIO input words of
//   IN_WIDTH bits into one FIFO word (lane 0 = LSBs) with a keep bit per
//   lane. i_last closes a word early. With FLUSH_TIMEOUT > 0, a partial word
//   that sees FLUSH_TIMEOUT idle cycles in a row is flushed. An accumulator
//   plus an output register give one input word per cycle of throughput
//   while the FIFO is not full.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_valid      input word valid
//   o_ready      adapter can accept a word (registered)
//   i_data       input word
//   i_last       last word of a packet, closes the current FIFO word
//   o_wr_en      FIFO write strobe (out_valid & ~i_fifo_full)
//   o_data       FIFO write data, zero while nothing is held
//   o_keep       lane-valid bits of o_data
//   i_fifo_full  FIFO full, blocks o_wr_en
//   o_busy       accumulator or output register holds data
//
// Handshake: a word is accepted at a rising edge where i_valid and o_ready
// are both high. The source keeps i_valid, i_data and i_last stable until
// that edge. o_ready depends only on registers.
module fifo_pack_writer #(
  parameter int IN_WIDTH      = 8,
  parameter int PACK_RATIO    = 4,
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [IN_WIDTH-1:0]            i_data,
  input  logic                           i_last,
  output logic                           o_wr_en,
  output logic [IN_WIDTH*PACK_RATIO-1:0] o_data,
  output logic [PACK_RATIO-1:0]          o_keep,
  input  logic                           i_fifo_full,
  output logic                           o_busy
);

  localparam int OW = IN_WIDTH * PACK_RATIO;
  localparam int LW = $clog2(PACK_RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK_RATIO - 1);

  typedef enum logic [1:0] {
    ACC_EMPTY    = 2'd0,
    ACC_FILLING  = 2'd1,
    ACC_COMPLETE = 2'd2
  } acc_state_t;

  acc_state_t            state, state_nx;
  logic [LW-1:0]         lane, lane_nx;
  logic [OW-1:0]         acc_data, acc_data_nx, acc_merged;
  logic [PACK_RATIO-1:0] acc_keep, acc_keep_nx, keep_merged;
  logic                  out_valid, out_valid_nx;
  logic [OW-1:0]         out_data, out_data_nx;
  logic [PACK_RATIO-1:0] out_keep, out_keep_nx;
  logic                  run;

  logic accept;
  logic drain;
  logic can_load;
  logic complete;
  logic timeout_hit;

  assign o_ready  = run & (state != ACC_COMPLETE);
  assign accept   = i_valid & o_ready;
  assign drain    = out_valid & ~i_fifo_full;
  assign can_load = ~out_valid | drain;
  assign o_wr_en  = drain;
  assign o_data   = out_data;
  assign o_keep   = out_keep;
  assign o_busy   = out_valid | (state == ACC_COMPLETE) | (lane != '0);

  // A word closes on its last lane, on i_last, or on an idle timeout.
  // accept already implies the accumulator is not COMPLETE.
  assign complete = (accept & ((lane == LAST_LANE) | i_last)) | timeout_hit;

  // Idle-timeout counter: counts cycles spent FILLING with no accept.
  generate
    if (FLUSH_TIMEOUT > 0) begin : g_timeout
      localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
      logic [TW-1:0] tcnt, tcnt_nx;

      // Flush on the edge at which the count would reach FLUSH_TIMEOUT;
      // a same-cycle accept wins because it is excluded here.
      assign timeout_hit = (state == ACC_FILLING) & ~accept &
                           (tcnt == TW'(FLUSH_TIMEOUT - 1));

      always_comb begin
        tcnt_nx = '0;
        if ((state == ACC_FILLING) && !accept && !timeout_hit) begin
          if (tcnt != TW'(FLUSH_TIMEOUT)) tcnt_nx = tcnt + TW'(1);
          else                            tcnt_nx = tcnt;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) tcnt <= '0;
        else        tcnt <= tcnt_nx;
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Accumulator contents including the word being accepted this cycle.
  always_comb begin
    acc_merged  = acc_data;
    keep_merged = acc_keep;
    if (accept) begin
      acc_merged[lane*IN_WIDTH +: IN_WIDTH] = i_data;
      keep_merged[lane]                     = 1'b1;
    end
  end

  // Next state for accumulator FSM and output register.
  always_comb begin
    state_nx     = state;
    lane_nx      = lane;
    acc_data_nx  = acc_data;
    acc_keep_nx  = acc_keep;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_keep_nx  = out_keep;

    // Output register returns to zero when it drains; a load below overrides.
    if (drain) begin
      out_valid_nx = 1'b0;
      out_data_nx  = '0;
      out_keep_nx  = '0;
    end

    if (state == ACC_COMPLETE) begin
      if (can_load) begin
        out_valid_nx = 1'b1;
        out_data_nx  = acc_data;
        out_keep_nx  = acc_keep;
        acc_data_nx  = '0;
        acc_keep_nx  = '0;
        state_nx     = ACC_EMPTY;
      end
    end else if (complete) begin
      lane_nx = '0;
      if (can_load) begin
        // Completed word goes straight to the output register.
        out_valid_nx = 1'b1;
        out_data_nx  = acc_merged;
        out_keep_nx  = keep_merged;
        acc_data_nx  = '0;
        acc_keep_nx  = '0;
        state_nx     = ACC_EMPTY;
      end else begin
        // Output register is held; park the word and stall the input.
        acc_data_nx = acc_merged;
        acc_keep_nx = keep_merged;
        state_nx    = ACC_COMPLETE;
      end
    end else if (accept) begin
      acc_data_nx = acc_merged;
      acc_keep_nx = keep_merged;
      lane_nx     = lane + LW'(1);
      state_nx    = ACC_FILLING;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ACC_EMPTY;
      lane      <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      run       <= 1'b0;
    end else begin
      state     <= state_nx;
      lane      <= lane_nx;
      acc_data  <= acc_data_nx;
      acc_keep  <= acc_keep_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_keep  <= out_keep_nx;
      run       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pack_writer.sv
module tb_fifo_pack_writer;
  localparam int W  = 8;
  localparam int PR = 4;
  localparam int FT = 16;
  localparam int OW = W * PR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic          i_last;
  logic          o_wr_en;
  logic [OW-1:0] o_data;
  logic [PR-1:0] o_keep;
  logic          i_fifo_full;
  logic          o_busy;

  fifo_pack_writer #(
    .IN_WIDTH(W),
    .PACK_RATIO(PR),
    .FLUSH_TIMEOUT(FT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(i_data),
    .i_last(i_last),
    .o_wr_en(o_wr_en),
    .o_data(o_data),
    .o_keep(o_keep),
    .i_fifo_full(i_fifo_full),
    .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard and reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [PR+OW-1:0] exp_q[$];
  logic [PR+OW-1:0] wr_word_q[$];
  int               wr_cyc_q[$];
  logic             ready_s = 1'b0;

  // Model: a FIFO word is the list of accepted bytes, closed by the 4th
  // byte, by i_last, or by FT consecutive idle cycles while partial.
  logic [OW-1:0] m_data;
  logic [PR-1:0] m_keep;
  int            m_lane = 0;
  int            m_idle = 0;
  logic [PR+OW-1:0] exp_word;

  always @(negedge clk) begin
    ready_s = o_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_data = '0;
      m_keep = '0;
      m_lane = 0;
      m_idle = 0;
    end else begin
      if (i_fifo_full === 1'b1) begin
        n_cmp++;
        if (o_wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_while_full: o_wr_en=%b required 0 (cyc %0d)", o_wr_en, cyc);
        end
      end else if (o_wr_en !== 1'b1) begin
        n_cmp++;
        if ({o_keep, o_data} !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs_zero: keep=%h data=%h required 0 (cyc %0d)", o_keep, o_data, cyc);
        end
      end
      if (o_wr_en === 1'b1) begin
        wr_cyc_q.push_back(cyc);
        wr_word_q.push_back({o_keep, o_data});
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: keep=%h data=%h required no write (cyc %0d)", o_keep, o_data, cyc);
        end else begin
          exp_word = exp_q.pop_front();
          if ({o_keep, o_data} !== exp_word) begin
            n_fail++;
            $display("FAIL write_word: got keep=%h data=%h required keep=%h data=%h (cyc %0d)",
                     o_keep, o_data, exp_word[PR+OW-1:OW], exp_word[OW-1:0], cyc);
          end
        end
      end
      if (i_valid && o_ready) begin
        m_data[m_lane*W +: W] = i_data;
        m_keep[m_lane]        = 1'b1;
        m_lane++;
        m_idle = 0;
        if (m_lane == PR || i_last) begin
          exp_q.push_back({m_keep, m_data});
          m_data = '0; m_keep = '0; m_lane = 0;
        end
      end else if (m_lane != 0) begin
        m_idle++;
        if (m_idle == FT) begin
          exp_q.push_back({m_keep, m_data});
          m_data = '0; m_keep = '0; m_lane = 0; m_idle = 0;
        end
      end
    end
  end

  function automatic int wc(input int i);
    return (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1;
  endfunction

  function automatic logic [PR+OW-1:0] ww(input int i);
    return (i < wr_word_q.size()) ? wr_word_q[i] : '1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cyc_q.delete();
    wr_word_q.delete();
  endtask

  // Presents one word and holds it until accepted; returns the accept cycle.
  task automatic send(input logic [W-1:0] d, input logic l, output int acc_cyc);
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (ready_s) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    acc_cyc = cyc;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 200 cycles", d);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_fifo_full = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({o_ready, o_wr_en, o_busy, o_keep, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b wr_en=%b busy=%b keep=%h data=%h required all 0",
               o_ready, o_wr_en, o_busy, o_keep, o_data);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_release: o_ready=%b required 0", o_ready);
    end
    tick();
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_run: o_ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_stream();
    int acc[8];
    clear_log();
    for (int i = 0; i < 8; i++) send(W'(i + 1), 1'b0, acc[i]);
    repeat (2) tick();
    n_cmp++;
    if (acc[7] - acc[0] != 7) begin
      n_fail++;
      $display("FAIL stream_ready_steady: 8 bytes took %0d cycles required 7", acc[7] - acc[0]);
    end
    n_cmp++;
    if (wc(0) != acc[3] || wc(1) != acc[7] || wr_cyc_q.size() != 2) begin
      n_fail++;
      $display("FAIL stream_latency: writes at %0d,%0d (n=%0d) required %0d,%0d",
               wc(0), wc(1), wr_cyc_q.size(), acc[3], acc[7]);
    end
    n_cmp++;
    if (ww(0) !== {4'hF, 32'h04030201} || ww(1) !== {4'hF, 32'h08070605}) begin
      n_fail++;
      $display("FAIL stream_words: got %h,%h required f04030201,f08070605", ww(0), ww(1));
    end
  endtask

  task automatic test_last();
    int a;
    logic [7:0] seq [7] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    clear_log();
    for (int i = 0; i < 7; i++) send(seq[i], (i == 2), a);
    repeat (2) tick();
    n_cmp++;
    if (ww(0) !== {4'b0111, 32'h00A2A1A0} || ww(1) !== {4'hF, 32'hB3B2B1B0}) begin
      n_fail++;
      $display("FAIL last_partial: got %h,%h required 700a2a1a0,fb3b2b1b0", ww(0), ww(1));
    end
    send(8'hC0, 1'b1, a);
    repeat (2) tick();
    n_cmp++;
    if (ww(2) !== {4'b0001, 32'h000000C0} || wc(2) != a) begin
      n_fail++;
      $display("FAIL last_lane0: got %h at %0d required 1000000c0 at %0d", ww(2), wc(2), a);
    end
  endtask

  task automatic test_fifo_full();
    int n_acc = 0;
    int a;
    int e;
    logic [7:0] b = 8'h10;
    clear_log();
    i_fifo_full = 1'b1;
    i_valid = 1'b1; i_last = 1'b0; i_data = b;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (ready_s) begin
        n_acc++;
        b++;
      end
      #1;
      i_data = b;
    end
    n_cmp++;
    if (n_acc != 8 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stall: accepted %0d ready=%b required 8 and 0", n_acc, o_ready);
    end
    i_fifo_full = 1'b0;
    e = cyc;
    tick();
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_back: o_ready=%b required 1", o_ready);
    end
    for (int i = 0; i < 4; i++) begin
      send(b, 1'b0, a);
      b++;
    end
    repeat (3) tick();
    n_cmp++;
    if (wc(0) != e || wc(1) != e + 1) begin
      n_fail++;
      $display("FAIL full_release_order: writes at %0d,%0d required %0d,%0d", wc(0), wc(1), e, e + 1);
    end
    n_cmp++;
    if (ww(0) !== {4'hF, 32'h13121110} || ww(1) !== {4'hF, 32'h17161514} ||
        ww(2) !== {4'hF, 32'h1B1A1918} || wr_word_q.size() != 3) begin
      n_fail++;
      $display("FAIL full_no_loss: got %h,%h,%h n=%0d required f13121110,f17161514,f1b1a1918 n=3",
               ww(0), ww(1), ww(2), wr_word_q.size());
    end
  endtask

  task automatic test_timeout();
    int a;
    clear_log();
    send(8'h11, 1'b0, a);
    send(8'h22, 1'b0, a);
    repeat (18) tick();
    n_cmp++;
    if (ww(0) !== {4'b0011, 32'h00002211} || wc(0) != a + 16 || wr_cyc_q.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_flush: got %h at %0d (n=%0d) required 300002211 at %0d",
               ww(0), wc(0), wr_cyc_q.size(), a + 16);
    end
    clear_log();
    send(8'h33, 1'b0, a);
    send(8'h44, 1'b0, a);
    repeat (15) tick();
    send(8'h55, 1'b0, a);
    repeat (15) tick();
    n_cmp++;
    if (wr_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_restart: %0d early writes required 0", wr_cyc_q.size());
    end
    repeat (3) tick();
    n_cmp++;
    if (ww(0) !== {4'b0111, 32'h00554433} || wc(0) != a + 16) begin
      n_fail++;
      $display("FAIL timeout_after_restart: got %h at %0d required 700554433 at %0d", ww(0), wc(0), a + 16);
    end
  endtask

  task automatic test_back_to_back();
    int acc[8];
    clear_log();
    i_fifo_full = 1'b1;
    for (int i = 0; i < 7; i++) send(W'(8'h20 + i), 1'b0, acc[i]);
    i_fifo_full = 1'b0;
    send(8'h27, 1'b0, acc[7]);
    n_cmp++;
    if (acc[7] - acc[0] != 7 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: 8 bytes took %0d cycles ready=%b required 7 and 1", acc[7] - acc[0], o_ready);
    end
    repeat (2) tick();
    n_cmp++;
    if (wc(0) != acc[7] - 1 || wc(1) != acc[7] ||
        ww(0) !== {4'hF, 32'h23222120} || ww(1) !== {4'hF, 32'h27262524}) begin
      n_fail++;
      $display("FAIL b2b_drain_load: %h@%0d %h@%0d required f23222120@%0d f27262524@%0d",
               ww(0), wc(0), ww(1), wc(1), acc[7] - 1, acc[7]);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    clear_log();
    i_fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) send(W'(8'h60 + i), 1'b0, a);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_ready, o_wr_en, o_busy, o_keep, o_data} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ready=%b wr_en=%b busy=%b keep=%h data=%h required all 0",
               o_ready, o_wr_en, o_busy, o_keep, o_data);
    end
    repeat (2) tick();
    i_fifo_full = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready_release: o_ready=%b required 0", o_ready);
    end
    repeat (25) tick();
    n_cmp++;
    if (wr_cyc_q.size() != 0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_discard: writes=%0d busy=%b ready=%b required 0,0,1",
               wr_cyc_q.size(), o_busy, o_ready);
    end
  endtask

  task automatic test_random();
    bit accepted;
    int gap = 0;
    i_valid = 1'b0; i_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      accepted = i_valid && ready_s;
      #1;
      if (!i_valid || accepted) begin
        if (gap > 0) begin
          i_valid = 1'b0;
          gap--;
        end else if ($urandom_range(0, 149) == 0) begin
          i_valid = 1'b0;
          gap = $urandom_range(10, 24);
        end else begin
          i_valid = ($urandom_range(0, 3) != 0);
          i_data  = W'($urandom);
          i_last  = ($urandom_range(0, 9) == 0);
        end
      end
      if ((c % 400) < 200) i_fifo_full = ($urandom_range(0, 5) == 0);
      else                 i_fifo_full = ($urandom_range(0, 1) == 0);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_last = 1'b0; i_fifo_full = 1'b0;
    repeat (40) tick();
    n_cmp++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: %0d words outstanding busy=%b required 0,0", exp_q.size(), o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_last();
    test_fifo_full();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_pack_writer.md
Name: fifo_pack_writer

Overview:
- Valid/ready-to-FIFO write adapter; successor to the single-word FIFO writer.
- Packs PACK_RATIO narrow input words into one wide FIFO word, with per-lane keep bits.
- Early packet termination via i_last; optional idle-timeout flush of partial words.
- Double-buffered (accumulator + output register): full throughput of one input word per cycle while the FIFO is not full.

Parameters:
IN_WIDTH, 8, width of one input word (>=1)
PACK_RATIO, 4, input words per FIFO word (>=2); FIFO word width = IN_WIDTH*PACK_RATIO
FLUSH_TIMEOUT, 0, idle cycles before a partial word is flushed; 0 disables the timeout

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  asynchronous active-low reset
i_valid  input  1  input word valid
o_ready  output  1  adapter can accept an input word
i_data  input  IN_WIDTH  input word
i_last  input  1  final word of packet; forces word completion
o_wr_en  output  1  FIFO write strobe; a write occurs in every cycle it is high
o_data  output  IN_WIDTH*PACK_RATIO  FIFO write data
o_keep  output  PACK_RATIO  lane-valid bits of o_data
i_fifo_full  input  1  FIFO full; no write is permitted while high
o_busy  output  1  accumulator or output register holds data

Behaviour:
- Reset (i_rst low, asynchronous):
  - Clears lane counter, accumulator, keep, acc_full, out_valid, out register, timeout counter and r_run.
  - o_ready=0, o_wr_en=0, o_data=0, o_keep=0, o_busy=0.
- r_run sets to 1 on the first clock edge after reset release.
- Accept: i_valid & o_ready at a rising edge.
  - o_ready = r_run & ~acc_full, from registers only.
  - i_data is stored in lane r_lane, bits [r_lane*IN_WIDTH +: IN_WIDTH]; keep[r_lane] is set.
  - Lane 0 is the LSBs. The first word after completion always goes to lane 0.
- Word completion, at the accept edge: r_lane==PACK_RATIO-1, or i_last=1. i_last on lane 0 gives keep=...0001.
- States of the accumulator:
  - EMPTY: r_lane=0, no keep bits set.
  - FILLING: partial word.
  - COMPLETE: acc_full=1, waiting for the output register.
- Output register: out_valid, out_data, out_keep. Drains in a cycle when o_wr_en = out_valid & ~i_fifo_full (combinational).
- Transfer of a completed word to the output register, at the completing edge or any later edge:
  - Condition: ~out_valid, or the output register drains in that cycle.
  - On transfer the accumulator returns to EMPTY in the same edge.
  - If the transfer is not possible, the accumulator enters COMPLETE and o_ready=0 from the next cycle.
  - From COMPLETE, transfer happens at the first edge satisfying the condition; o_ready returns to 1 the next cycle.
- Latency: completing accept at edge N -> o_wr_en high in cycle after N, if the FIFO is not full.
- Sustained throughput is 1 input word/cycle when i_fifo_full=0.
- Unused lanes of o_data are 0. o_data and o_keep are 0 whenever out_valid=0.
- Timeout (FLUSH_TIMEOUT>0):
  - The counter increments each cycle the accumulator is FILLING and no accept occurs.
  - It clears on any accept and whenever the accumulator is not FILLING.
  - When the count reaches FLUSH_TIMEOUT, the partial word is treated as completed at that edge and follows the transfer rules.
  - An accept in the same cycle takes priority: the word is stored and the counter clears.
- Counter width: $clog2(FLUSH_TIMEOUT+1); saturates, never wraps.
- No data loss or duplication under any i_fifo_full pattern. Word order is preserved.
- o_busy = out_valid | acc_full | (r_lane!=0).
- Reset mid-operation discards all held data; no o_wr_en is produced for it.

Test Plan:
- Reset asserted mid-stream, released -> all outputs 0 during reset; o_ready=0 the first cycle after release, then 1; no write of discarded data.
- IN_WIDTH=8, PACK_RATIO=4, i_fifo_full=0, continuous bytes 0x01..0x08 -> two writes, o_data=0x04030201 then 0x08070605, o_keep=4'hF both; o_ready stays 1; each o_wr_en one cycle after the 4th byte accept.
- Bytes 0xA0,0xA1,0xA2 with i_last on 0xA2, then 0xB0 -> write o_data=0x00A2A1A0, o_keep=4'b0111; 0xB0 lands in lane 0 of the next word.
- i_fifo_full held high for 20 cycles while streaming -> o_ready drops after exactly 8 accepted bytes. On release: words written in order on consecutive cycles, o_ready high again; no loss.
- FLUSH_TIMEOUT=16, two bytes 0x11,0x22 then idle -> after 16 idle cycles, o_wr_en with o_data=0x00002211, o_keep=4'b0011. A byte sent on idle cycle 15 instead -> no flush, counter restarts.
- Completion and drain in the same cycle (out_valid=1, i_fifo_full=0, 4th byte accepted) -> old word written, new word loaded at that edge, o_ready never drops.
